// File: rtl/vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vend_ctrl
// Description : Four-item vending machine controller. Collects 5/10/25 cent
//               coins against a per-item price, vends, then returns change
//               through a valid/ack handshake. Cancel or an idle timeout
//               refunds the collected credit.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_ctrl #(
  parameter int PRICE0  = 25,
  parameter int PRICE1  = 50,
  parameter int PRICE2  = 75,
  parameter int PRICE3  = 100,
  parameter int TIMEOUT = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] sel,
  input  logic       coin,
  input  logic [1:0] coin_val,
  input  logic       cancel,
  input  logic       change_ack,
  output logic [2:0] state,
  output logic [7:0] credit,
  output logic [1:0] item_out,
  output logic       dispense,
  output logic [7:0] change,
  output logic       change_valid,
  output logic       coin_reject
);

  localparam int                  c_TCNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_TCNT_W-1:0] c_TCNT_ONE  = c_TCNT_W'(1);
  localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(TIMEOUT - 1);
  localparam logic [7:0]          c_PRICE0    = 8'(PRICE0);
  localparam logic [7:0]          c_PRICE1    = 8'(PRICE1);
  localparam logic [7:0]          c_PRICE2    = 8'(PRICE2);
  localparam logic [7:0]          c_PRICE3    = 8'(PRICE3);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_SELECT   = 3'b001,
    S_COLLECT  = 3'b010,
    S_DISPENSE = 3'b011,
    S_CHANGE   = 3'b100,
    S_REFUND   = 3'b101
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [7:0]          r_credit, w_credit_nxt;
  logic [7:0]          r_price, w_price_nxt;
  logic [7:0]          r_change, w_change_nxt;
  logic [1:0]          r_item, w_item_nxt;
  logic [c_TCNT_W-1:0] r_tcnt, w_tcnt_nxt;
  logic                r_coin_reject, w_coin_reject_nxt;

  logic [7:0]          w_coin_amt;
  logic [7:0]          w_sel_price;
  logic                w_paid;
  logic                w_coin_ok;
  logic                w_tcnt_last;

  // Decode the coin value into cents; the invalid code contributes nothing.
  always_comb begin
    w_coin_amt = 8'd0;
    case (coin_val)
      2'b00:   w_coin_amt = 8'd5;
      2'b01:   w_coin_amt = 8'd10;
      2'b10:   w_coin_amt = 8'd25;
      default: w_coin_amt = 8'd0;
    endcase
  end

  // Price lookup for the latched item.
  always_comb begin
    w_sel_price = c_PRICE0;
    case (r_item)
      2'd0:    w_sel_price = c_PRICE0;
      2'd1:    w_sel_price = c_PRICE1;
      2'd2:    w_sel_price = c_PRICE2;
      default: w_sel_price = c_PRICE3;
    endcase
  end

  // Exit from COLLECT is decided on the registered credit. A coin arriving on
  // that exit cycle is bounced back rather than credited, which keeps credit
  // at most price+20 (the largest overshoot a single 25c coin can cause).
  assign w_paid      = (r_credit >= r_price);
  assign w_coin_ok   = coin && (coin_val != 2'b11) && (r_state == S_COLLECT) && !w_paid;
  assign w_tcnt_last = (r_tcnt == c_TCNT_LAST);

  // Next-state and next-register values for the controller.
  always_comb begin
    w_state_nxt       = r_state;
    w_credit_nxt      = r_credit;
    w_price_nxt       = r_price;
    w_change_nxt      = r_change;
    w_item_nxt        = r_item;
    w_tcnt_nxt        = r_tcnt;
    w_coin_reject_nxt = coin && !w_coin_ok;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_item_nxt   = sel;
          w_credit_nxt = 8'd0;
          w_change_nxt = 8'd0;
          w_state_nxt  = S_SELECT;
        end
      end

      S_SELECT: begin
        w_price_nxt = w_sel_price;
        w_tcnt_nxt  = '0;
        w_state_nxt = S_COLLECT;
      end

      S_COLLECT: begin
        // A coin on the cancel cycle is credited first so the refund covers it.
        if (w_coin_ok) begin
          w_credit_nxt = r_credit + w_coin_amt;
          w_tcnt_nxt   = '0;
        end else begin
          w_tcnt_nxt   = r_tcnt + c_TCNT_ONE;
        end

        if (w_paid) begin
          w_state_nxt = S_DISPENSE;
        end else if (cancel) begin
          w_state_nxt = S_REFUND;
        end else if (!w_coin_ok && w_tcnt_last) begin
          w_state_nxt = S_REFUND;
        end
      end

      S_DISPENSE: begin
        w_change_nxt = r_credit - r_price;
        w_state_nxt  = S_CHANGE;
      end

      S_REFUND: begin
        w_change_nxt = r_credit;
        w_state_nxt  = S_CHANGE;
      end

      S_CHANGE: begin
        // Nothing owed: close the transaction without a handshake.
        if (r_change == 8'd0) begin
          w_credit_nxt = 8'd0;
          w_state_nxt  = S_IDLE;
        end else if (change_ack) begin
          w_change_nxt = 8'd0;
          w_credit_nxt = 8'd0;
          w_state_nxt  = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_credit      <= 8'd0;
      r_price       <= 8'd0;
      r_change      <= 8'd0;
      r_item        <= 2'd0;
      r_tcnt        <= '0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_price       <= w_price_nxt;
      r_change      <= w_change_nxt;
      r_item        <= w_item_nxt;
      r_tcnt        <= w_tcnt_nxt;
      r_coin_reject <= w_coin_reject_nxt;
    end
  end

  assign state        = r_state;
  assign credit       = r_credit;
  assign item_out     = r_item;
  assign change       = r_change;
  assign coin_reject  = r_coin_reject;
  assign dispense     = (r_state == S_DISPENSE);
  assign change_valid = (r_state == S_CHANGE) && (r_change != 8'd0);

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_ctrl
// Description : Directed-vector bench for vend_ctrl: a table of per-cycle
//               stimulus with expected outputs, plus hand-written timeout and
//               asynchronous-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] sel;
  logic       coin;
  logic [1:0] coin_val;
  logic       cancel;
  logic       change_ack;
  logic [2:0] state;
  logic [7:0] credit;
  logic [1:0] item_out;
  logic       dispense;
  logic [7:0] change;
  logic       change_valid;
  logic       coin_reject;

  int n_cmp = 0;
  int n_bad = 0;

  // 100 MHz-style clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  vend_ctrl #(
    .PRICE0 (25),
    .PRICE1 (50),
    .PRICE2 (75),
    .PRICE3 (100),
    .TIMEOUT(200)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sel         (sel),
    .coin        (coin),
    .coin_val    (coin_val),
    .cancel      (cancel),
    .change_ack  (change_ack),
    .state       (state),
    .credit      (credit),
    .item_out    (item_out),
    .dispense    (dispense),
    .change      (change),
    .change_valid(change_valid),
    .coin_reject (coin_reject)
  );

  typedef struct {
    logic       st;
    logic [1:0] sl;
    logic       cn;
    logic [1:0] cv;
    logic       ca;
    logic       ak;
    logic [2:0] e_state;
    logic [7:0] e_credit;
    logic [1:0] e_item;
    logic       e_disp;
    logic [7:0] e_chg;
    logic       e_cvld;
    logic       e_rej;
  } vec_t;

  vec_t vq[$];

  function automatic logic [23:0] outs();
    return {state, credit, item_out, dispense, change, change_valid, coin_reject};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start      = 1'b0;
    sel        = 2'd0;
    coin       = 1'b0;
    coin_val   = 2'd0;
    cancel     = 1'b0;
    change_ack = 1'b0;
  endtask

  // Hard stop in case a sequence stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nidle;
    int ncol;

    // Fields: st sl cn cv ca ak | state credit item disp change cvld rej
    // sel=01 (50c): invalid coin, then 25+10+25 = 60, change 10 held until ack.
    vq.push_back('{1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 3'd1, 8'd0,  2'd1, 1'b0, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b1, 2'd2, 1'b1, 1'b0, 3'd2, 8'd0,  2'd1, 1'b0, 8'd0,  1'b0, 1'b1});
    vq.push_back('{1'b0, 2'd0, 1'b1, 2'd3, 1'b0, 1'b0, 3'd2, 8'd0,  2'd1, 1'b0, 8'd0,  1'b0, 1'b1});
    vq.push_back('{1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0, 3'd2, 8'd25, 2'd1, 1'b0, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b1, 2'd3, 1'b1, 2'd1, 1'b0, 1'b0, 3'd2, 8'd35, 2'd1, 1'b0, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0, 3'd2, 8'd60, 2'd1, 1'b0, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd3, 8'd60, 2'd1, 1'b1, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd4, 8'd60, 2'd1, 1'b0, 8'd10, 1'b1, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd4, 8'd60, 2'd1, 1'b0, 8'd10, 1'b1, 1'b0});
    vq.push_back('{1'b1, 2'd2, 1'b0, 2'd0, 1'b1, 1'b0, 3'd4, 8'd60, 2'd1, 1'b0, 8'd10, 1'b1, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0, 8'd0,  2'd1, 1'b0, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b1, 3'd0, 8'd0,  2'd1, 1'b0, 8'd0,  1'b0, 1'b1});
    // sel=00 (25c): exact payment, zero change, no handshake.
    vq.push_back('{1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd1, 8'd0,  2'd0, 1'b0, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd2, 8'd0,  2'd0, 1'b0, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0, 3'd2, 8'd25, 2'd0, 1'b0, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd3, 8'd25, 2'd0, 1'b1, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd4, 8'd25, 2'd0, 1'b0, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd0, 8'd0,  2'd0, 1'b0, 8'd0,  1'b0, 1'b0});
    // sel=10 (75c): 10c coin together with cancel, refund of 10.
    vq.push_back('{1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 3'd1, 8'd0,  2'd2, 1'b0, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd2, 8'd0,  2'd2, 1'b0, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0, 3'd5, 8'd10, 2'd2, 1'b0, 8'd0,  1'b0, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 3'd4, 8'd10, 2'd2, 1'b0, 8'd10, 1'b1, 1'b0});
    vq.push_back('{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 3'd0, 8'd0,  2'd2, 1'b0, 8'd0,  1'b0, 1'b0});

    // Reset state.
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    check("reset_state", 32'(outs()), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven vectors.
    foreach (vq[i]) begin
      start      = vq[i].st;
      sel        = vq[i].sl;
      coin       = vq[i].cn;
      coin_val   = vq[i].cv;
      cancel     = vq[i].ca;
      change_ack = vq[i].ak;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vq[i].e_state, vq[i].e_credit, vq[i].e_item, vq[i].e_disp,
                 vq[i].e_chg, vq[i].e_cvld, vq[i].e_rej}));
    end
    idle_inputs();

    // Timeout: sel=11, one 5c coin, then idle until refund; count COLLECT cycles.
    ncol  = 0;
    start = 1'b1;
    sel   = 2'd3;
    tick();
    ncol += int'(state == 3'b010);
    start = 1'b0;
    tick();
    ncol += int'(state == 3'b010);
    coin     = 1'b1;
    coin_val = 2'b00;
    tick();
    ncol += int'(state == 3'b010);
    coin = 1'b0;
    check("to_credit", 32'(credit), 32'd5);
    nidle = 0;
    while (state == 3'b010 && nidle < 300) begin
      tick();
      nidle++;
      ncol += int'(state == 3'b010);
    end
    check("to_idle_cycles", 32'(nidle), 32'd200);
    check("to_refund_state", 32'(state), 32'd5);
    tick();
    ncol += int'(state == 3'b010);
    check("to_change", 32'({state, change_valid, change}), 32'({3'd4, 1'b1, 8'd5}));
    change_ack = 1'b1;
    tick();
    ncol += int'(state == 3'b010);
    change_ack = 1'b0;
    check("to_back_idle", 32'({state, change_valid, change, credit}), 32'd0);
    check("collect_window", 32'(ncol), 32'd201);

    // Asynchronous reset while change is pending: sel=00, three 10c coins.
    start = 1'b1;
    sel   = 2'd0;
    tick();
    start = 1'b0;
    tick();
    coin     = 1'b1;
    coin_val = 2'b01;
    tick();
    tick();
    tick();
    coin = 1'b0;
    check("rst_pre_credit", 32'(credit), 32'd30);
    tick();
    tick();
    check("rst_pre_change", 32'({state, change_valid, change}), 32'({3'd4, 1'b1, 8'd5}));
    #2;
    reset = 1'b0;
    #1;
    check("rst_async", 32'(outs()), 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    cancel = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rst_hold%0d", k), 32'(outs()), 32'd0);
    end
    cancel = 1'b0;
    start  = 1'b1;
    sel    = 2'd2;
    tick();
    start = 1'b0;
    check("rst_restart", 32'({state, item_out}), 32'({3'd1, 2'd2}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
